// File: rtl/cdb_arbiter_if.sv
// Bundle of EU offer lanes and the CDB output word shared by the arbiter and its neighbours.
// The master side drives offers and the ROB acknowledge; the slave side is the arbiter itself.
interface cdb_arbiter_if #(
  parameter int N_EU        = 4,
  parameter int ROB_IDX_LEN = 3,
  parameter int EXCEPT_LEN  = 4,
  parameter int XLEN        = 64
);
  logic [N_EU-1:0]             eu_valid_i;
  logic [N_EU-1:0]             eu_ready_o;
  logic [N_EU*ROB_IDX_LEN-1:0] eu_idx_i;
  logic [N_EU*XLEN-1:0]        eu_data_i;
  logic [N_EU-1:0]             eu_except_raised_i;
  logic [N_EU*EXCEPT_LEN-1:0]  eu_except_code_i;
  logic                        cdb_ready_i;
  logic                        cdb_valid_o;
  logic [ROB_IDX_LEN-1:0]      cdb_idx_o;
  logic [XLEN-1:0]             cdb_data_o;
  logic                        cdb_except_raised_o;
  logic [EXCEPT_LEN-1:0]       cdb_except_code_o;

  modport master (
    output eu_valid_i, eu_idx_i, eu_data_i, eu_except_raised_i, eu_except_code_i, cdb_ready_i,
    input  eu_ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_code_o
  );

  modport slave (
    input  eu_valid_i, eu_idx_i, eu_data_i, eu_except_raised_i, eu_except_code_i, cdb_ready_i,
    output eu_ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o, cdb_except_code_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among N_EU execution units.
// One offer per cycle is latched into a single output register that the ROB drains.
module cdb_arbiter #(
  parameter int N_EU        = 4,
  parameter int ROB_IDX_LEN = 3,
  parameter int EXCEPT_LEN  = 4,
  parameter int XLEN        = 64
) (
  input logic           clk_i,
  input logic           rst_i,
  input logic           flush_i,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(N_EU);

  logic [PTR_W-1:0]       rr_ptr;
  logic                   vld_p1;
  logic [ROB_IDX_LEN-1:0] idx_p1;
  logic [XLEN-1:0]        data_p1;
  logic                   exr_p1;
  logic [EXCEPT_LEN-1:0]  exc_p1;

  logic [ROB_IDX_LEN-1:0] eu_idx_a  [N_EU];
  logic [XLEN-1:0]        eu_data_a [N_EU];
  logic [EXCEPT_LEN-1:0]  eu_exc_a  [N_EU];

  logic             load_en;
  logic [PTR_W:0]   pick;
  logic             grant;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] next_ptr;

  // Returns {found, index} of the first requester at or after ptr, wrapping modulo N_EU.
  // Walking the offsets downward lets the nearest requester overwrite farther ones.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_EU-1:0] req,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0] res;
    int             k;
    res = '0;
    for (int j = N_EU - 1; j >= 0; j--) begin
      k = (int'(ptr) + j) % N_EU;
      if (req[PTR_W'(k)]) res = {1'b1, PTR_W'(k)};
    end
    return res;
  endfunction

  for (genvar g = 0; g < N_EU; g++) begin : g_unpack
    assign eu_idx_a[g]  = bus.eu_idx_i[g*ROB_IDX_LEN +: ROB_IDX_LEN];
    assign eu_data_a[g] = bus.eu_data_i[g*XLEN +: XLEN];
    assign eu_exc_a[g]  = bus.eu_except_code_i[g*EXCEPT_LEN +: EXCEPT_LEN];
  end

  // Stage p0: combinational grant; the register may load whenever it is empty or being drained.
  assign load_en  = ~flush_i & ~rst_i & (~vld_p1 | bus.cdb_ready_i);
  assign pick     = rr_pick(bus.eu_valid_i, rr_ptr);
  assign gnt_idx  = pick[PTR_W-1:0];
  assign grant    = pick[PTR_W] & load_en;
  assign next_ptr = (gnt_idx == PTR_W'(N_EU - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    bus.eu_ready_o = '0;
    if (grant) bus.eu_ready_o[gnt_idx] = 1'b1;
  end

  // Stage p1: the CDB word register. Fields are held when the word drains without a refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      idx_p1  <= '0;
      data_p1 <= '0;
      exr_p1  <= 1'b0;
      exc_p1  <= '0;
    end else if (grant) begin
      rr_ptr  <= next_ptr;
      vld_p1  <= 1'b1;
      idx_p1  <= eu_idx_a[gnt_idx];
      data_p1 <= eu_data_a[gnt_idx];
      exr_p1  <= bus.eu_except_raised_i[gnt_idx];
      exc_p1  <= eu_exc_a[gnt_idx];
    end else if (flush_i || bus.cdb_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.cdb_valid_o         = vld_p1;
  assign bus.cdb_idx_o           = idx_p1;
  assign bus.cdb_data_o          = data_p1;
  assign bus.cdb_except_raised_o = exr_p1;
  assign bus.cdb_except_code_o   = exc_p1;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-free behavioural model of the arbiter.
module tb_cdb_arbiter;
  localparam int N_EU = 4;
  localparam int RL   = 3;
  localparam int EL   = 4;
  localparam int XL   = 64;
  localparam int PW   = $clog2(N_EU);

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_EU(N_EU), .ROB_IDX_LEN(RL), .EXCEPT_LEN(EL), .XLEN(XL)) bus ();

  cdb_arbiter #(.N_EU(N_EU), .ROB_IDX_LEN(RL), .EXCEPT_LEN(EL), .XLEN(XL)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus)
  );

  logic [RL-1:0] t_idx  [N_EU];
  logic [XL-1:0] t_data [N_EU];
  logic [EL-1:0] t_exc  [N_EU];

  for (genvar g = 0; g < N_EU; g++) begin : g_pack
    assign bus.eu_idx_i[g*RL +: RL]         = t_idx[g];
    assign bus.eu_data_i[g*XL +: XL]        = t_data[g];
    assign bus.eu_except_code_i[g*EL +: EL] = t_exc[g];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the CDB word and the rotating priority start, in plain integers.
  bit            m_known = 1'b0;
  int            m_rr;
  bit            m_vld;
  logic [RL-1:0] m_idx;
  logic [XL-1:0] m_data;
  bit            m_exr;
  logic [EL-1:0] m_exc;
  int            m_gnt;

  function automatic int model_grant();
    if (rst || flush || (m_vld && !bus.cdb_ready_i)) return -1;
    for (int j = 0; j < N_EU; j++) begin
      int k;
      k = (m_rr + j) % N_EU;
      if (bus.eu_valid_i[k]) return k;
    end
    return -1;
  endfunction

  task automatic settle();
    logic [N_EU-1:0] exp_rdy;
    #2;
    m_gnt   = model_grant();
    exp_rdy = '0;
    if (m_gnt >= 0) exp_rdy[m_gnt[PW-1:0]] = 1'b1;
    chk("eu_ready", bus.eu_ready_o, exp_rdy);
    if (m_known) begin
      chk("cdb_valid", bus.cdb_valid_o, m_vld);
      chk("cdb_idx", bus.cdb_idx_o, m_idx);
      chk("cdb_data", bus.cdb_data_o, m_data);
      chk("cdb_exr", bus.cdb_except_raised_o, m_exr);
      chk("cdb_exc", bus.cdb_except_code_o, m_exc);
    end
  endtask

  task automatic advance();
    if (rst) begin
      m_known = 1'b1;
      m_rr = 0; m_vld = 1'b0; m_idx = '0; m_data = '0; m_exr = 1'b0; m_exc = '0;
    end else if (flush) begin
      m_vld = 1'b0;
    end else if (m_gnt >= 0) begin
      m_vld  = 1'b1;
      m_idx  = t_idx[m_gnt[PW-1:0]];
      m_data = t_data[m_gnt[PW-1:0]];
      m_exr  = bus.eu_except_raised_i[m_gnt[PW-1:0]];
      m_exc  = t_exc[m_gnt[PW-1:0]];
      m_rr   = (m_gnt + 1) % N_EU;
    end else if (m_vld && bus.cdb_ready_i) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_eu(input int k, input logic [RL-1:0] idx, input logic [XL-1:0] data,
                        input logic exr, input logic [EL-1:0] exc);
    t_idx[k]  = idx;
    t_data[k] = data;
    t_exc[k]  = exc;
    bus.eu_except_raised_i[k] = exr;
  endtask

  task automatic randomize_fields();
    for (int k = 0; k < N_EU; k++)
      set_eu(k, RL'($urandom), {$urandom, $urandom}, 1'($urandom), EL'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.cdb_ready_i = 1'b1;
    bus.eu_valid_i = '1;
    bus.eu_except_raised_i = '0;
    randomize_fields();

    // Reset with every EU requesting: nothing may be granted.
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("rst_ready", bus.eu_ready_o, 4'b0000);
      advance();
    end
    rst = 1'b0;
    bus.eu_valid_i = '0;
    settle();
    chk("rst_out_valid", bus.cdb_valid_o, 1'b0);
    chk("rst_out_data", bus.cdb_data_o, 64'h0);
    chk("rst_out_idx", bus.cdb_idx_o, 3'd0);
    advance();

    // Single requester EU2.
    for (int k = 0; k < N_EU; k++) set_eu(k, 3'd0, 64'h0, 1'b0, 4'h0);
    set_eu(2, 3'd5, 64'hDEAD, 1'b0, 4'h0);
    bus.eu_valid_i = 4'b0100;
    settle();
    chk("single_ready", bus.eu_ready_o, 4'b0100);
    advance();
    bus.eu_valid_i = 4'b0000;
    settle();
    chk("single_valid", bus.cdb_valid_o, 1'b1);
    chk("single_idx", bus.cdb_idx_o, 3'd5);
    chk("single_data", bus.cdb_data_o, 64'hDEAD);
    advance();

    // Round robin from pointer 0 with all EUs requesting.
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    for (int k = 0; k < N_EU; k++) set_eu(k, RL'(k + 1), 64'(100 + k), 1'b0, 4'h0);
    bus.eu_valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      logic [N_EU-1:0] exp_g;
      exp_g = '0;
      exp_g[c % N_EU] = 1'b1;
      settle();
      chk("rr_grant", bus.eu_ready_o, exp_g);
      if (c > 0) chk("rr_cdb_idx", bus.cdb_idx_o, 64'((c - 1) % N_EU + 1));
      advance();
    end

    // Backpressure: hold an idx=2 word for three cycles, then release.
    bus.eu_valid_i = 4'b0010;
    set_eu(1, 3'd2, 64'h2222, 1'b0, 4'h0);
    set_eu(0, 3'd6, 64'h6666, 1'b0, 4'h0);
    settle();
    advance();
    bus.cdb_ready_i = 1'b0;
    bus.eu_valid_i = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_ready", bus.eu_ready_o, 4'b0000);
      chk("bp_idx", bus.cdb_idx_o, 3'd2);
      chk("bp_valid", bus.cdb_valid_o, 1'b1);
      advance();
    end
    bus.cdb_ready_i = 1'b1;
    settle();
    chk("bp_release_ready", bus.eu_ready_o, 4'b0001);
    advance();
    bus.eu_valid_i = 4'b0000;
    settle();
    chk("bp_new_idx", bus.cdb_idx_o, 3'd6);

    // Flush while a word is valid and EU3 requests.
    bus.eu_valid_i = 4'b1000;
    flush = 1'b1;
    settle();
    chk("flush_ready", bus.eu_ready_o, 4'b0000);
    advance();
    flush = 1'b0;
    settle();
    chk("flush_valid", bus.cdb_valid_o, 1'b0);
    chk("post_flush_ready", bus.eu_ready_o, 4'b1000);
    advance();

    // Exception passthrough from EU1.
    set_eu(1, 3'd4, 64'h1234, 1'b1, 4'h2);
    bus.eu_valid_i = 4'b0010;
    settle();
    chk("exc_ready", bus.eu_ready_o, 4'b0010);
    advance();
    bus.eu_valid_i = 4'b0000;
    settle();
    chk("exc_valid", bus.cdb_valid_o, 1'b1);
    chk("exc_raised", bus.cdb_except_raised_o, 1'b1);
    chk("exc_code", bus.cdb_except_code_o, 4'h2);
    advance();
    settle();
    chk("exc_gone", bus.cdb_valid_o, 1'b0);
    advance();

    // Randomized traffic with backpressure, flushes and occasional resets.
    for (int c = 0; c < 600; c++) begin
      randomize_fields();
      bus.eu_valid_i  = N_EU'($urandom);
      bus.cdb_ready_i = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 19) == 0);
      rst             = ($urandom_range(0, 49) == 0);
      settle();
      advance();
    end
    rst = 1'b0;
    flush = 1'b0;
    bus.eu_valid_i = '0;
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
